auth_request_port: RTL

- PD-side request port that feeds the authentication driver and consumes its replies.
- Queues 8-bit authentication request words from the PD/host side and presents the head word on the driver's pending-request input. Pops the word when the driver signals erase.
- Captures the driver's outgoing message (plain or USB-framed) and splits it into fields. Handshakes Ack back to the driver, then hands the parsed response to the host with valid/ready.

---
 rtl/auth_request_port.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/auth_request_port.sv
// PD-side request port: queues host authentication request words for the driver,
// then captures, acknowledges and hands back the driver's reply message.
module auth_request_port #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int MSG_LEN        = 2080,
  parameter int USB_LEN        = 2112
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  input  logic [7:0]          req_data,
  output logic                req_ready,
  output logic [7:0]          pending_auth_request,
  input  logic                pending_auth_request_erase,
  input  logic                auth_msg_ready,
  input  logic [MSG_LEN-1:0]  auth_msg_out,
  input  logic [USB_LEN-1:0]  auth_msg_out_USB,
  output logic                Ack_out,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [1:0]          rsp_slot,
  output logic                rsp_usb,
  output logic [7:0]          rsp_bmRequestType,
  output logic [7:0]          rsp_bRequest,
  output logic [15:0]         rsp_wLength,
  output logic [31:0]         rsp_header,
  output logic [MSG_LEN-33:0] rsp_payload,
  output logic                err_bad_req,
  output logic                err_timeout
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRESENT  = 3'd1,
    WAIT_MSG = 3'd2,
    ACK_HOLD = 3'd3,
    DELIVER  = 3'd4
  } state_t;

  // Only responder (01) and initiator (10) roles are meaningful to the driver.
  function automatic logic role_ok(input logic [7:0] word);
    return (word[5:4] == 2'b01) || (word[5:4] == 2'b10);
  endfunction

  state_t             state_r, state_s;
  logic [7:0]         mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]   count_r, count_s;
  logic               full_r;
  logic [TMR_W-1:0]   timer_r, timer_s;
  logic               push_s, bad_s, pop_s, capture_s, timeout_s;
  logic [7:0]         head_s;
  logic               inflight_usb_r;

  logic [7:0]         pending_r;
  logic               ack_r, rsp_valid_r, err_bad_req_r, err_timeout_r;
  logic [1:0]         rsp_slot_r;
  logic               rsp_usb_r;
  logic [7:0]         rsp_bm_r, rsp_breq_r;
  logic [15:0]        rsp_wlen_r;
  logic [31:0]        rsp_header_r;
  logic [MSG_LEN-33:0] rsp_payload_r;

  assign req_ready = !full_r;
  assign push_s    = req_valid && !full_r && role_ok(req_data);
  assign bad_s     = req_valid && !full_r && !role_ok(req_data);
  assign head_s    = mem_r[rd_ptr_r];
  assign count_s   = count_r + CNT_W'(push_s) - CNT_W'(pop_s);

  // Request FIFO storage, pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= 8'h00;
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      full_r   <= 1'b0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= req_data;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r <= count_s;
      full_r  <= (count_s == CNT_FULL);
    end
  end

  // Transaction state and timeout timer registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      timer_r <= {TMR_W{1'b0}};
    end else begin
      state_r <= state_s;
      timer_r <= timer_s;
    end
  end

  // Next-state, pop/capture strobes and timer update
  always_comb begin
    state_s   = state_r;
    timer_s   = timer_r;
    pop_s     = 1'b0;
    capture_s = 1'b0;
    timeout_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (count_r != {CNT_W{1'b0}}) begin
          state_s = PRESENT;
        end else begin
          state_s = IDLE;
        end
      end
      PRESENT: begin
        if (pending_auth_request_erase) begin
          pop_s   = 1'b1;
          timer_s = {TMR_W{1'b0}};
          state_s = WAIT_MSG;
        end else begin
          state_s = PRESENT;
        end
      end
      WAIT_MSG: begin
        if (auth_msg_ready) begin
          capture_s = 1'b1;
          timer_s   = {TMR_W{1'b0}};
          state_s   = ACK_HOLD;
        end else if (timer_r == TMR_LAST) begin
          timeout_s = 1'b1;
          timer_s   = {TMR_W{1'b0}};
          state_s   = IDLE;
        end else begin
          timer_s = timer_r + TMR_W'(1);
        end
      end
      ACK_HOLD: begin
        // A stuck driver still gets its captured reply delivered after the abort.
        if (!auth_msg_ready) begin
          timer_s = {TMR_W{1'b0}};
          state_s = DELIVER;
        end else if (timer_r == TMR_LAST) begin
          timeout_s = 1'b1;
          timer_s   = {TMR_W{1'b0}};
          state_s   = DELIVER;
        end else begin
          timer_s = timer_r + TMR_W'(1);
        end
      end
      DELIVER: begin
        if (rsp_valid_r && rsp_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DELIVER;
        end
      end
      default: begin
        state_s = IDLE;
        timer_s = {TMR_W{1'b0}};
      end
    endcase
  end

  // Registered outputs and capture of the driver message into response fields
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_r      <= 8'h00;
      ack_r          <= 1'b0;
      rsp_valid_r    <= 1'b0;
      err_bad_req_r  <= 1'b0;
      err_timeout_r  <= 1'b0;
      inflight_usb_r <= 1'b0;
      rsp_slot_r     <= 2'b00;
      rsp_usb_r      <= 1'b0;
      rsp_bm_r       <= 8'h00;
      rsp_breq_r     <= 8'h00;
      rsp_wlen_r     <= 16'h0000;
      rsp_header_r   <= 32'h0000_0000;
      rsp_payload_r  <= {(MSG_LEN-32){1'b0}};
    end else begin
      pending_r     <= (state_s == PRESENT) ? head_s : 8'h00;
      ack_r         <= (state_s == ACK_HOLD);
      // rsp_valid rises one cycle into DELIVER, after Ack_out has dropped.
      rsp_valid_r   <= (state_r == DELIVER) && (state_s == DELIVER);
      err_bad_req_r <= bad_s;
      err_timeout_r <= timeout_s;
      if (pop_s) begin
        rsp_slot_r     <= head_s[7:6];
        inflight_usb_r <= (head_s[3:2] != 2'b00);
      end
      if (capture_s) begin
        if (inflight_usb_r) begin
          rsp_usb_r     <= 1'b1;
          rsp_bm_r      <= auth_msg_out_USB[USB_LEN-1 -: 8];
          rsp_breq_r    <= auth_msg_out_USB[USB_LEN-9 -: 8];
          rsp_header_r  <= auth_msg_out_USB[USB_LEN-17 -: 32];
          rsp_wlen_r    <= auth_msg_out_USB[USB_LEN-49 -: 16];
          rsp_payload_r <= auth_msg_out_USB[USB_LEN-65:0];
        end else begin
          rsp_usb_r     <= 1'b0;
          rsp_bm_r      <= 8'h00;
          rsp_breq_r    <= 8'h00;
          rsp_header_r  <= auth_msg_out[MSG_LEN-1 -: 32];
          rsp_wlen_r    <= 16'h0000;
          rsp_payload_r <= auth_msg_out[MSG_LEN-33:0];
        end
      end
    end
  end

  assign pending_auth_request = pending_r;
  assign Ack_out              = ack_r;
  assign rsp_valid            = rsp_valid_r;
  assign rsp_slot             = rsp_slot_r;
  assign rsp_usb              = rsp_usb_r;
  assign rsp_bmRequestType    = rsp_bm_r;
  assign rsp_bRequest         = rsp_breq_r;
  assign rsp_wLength          = rsp_wlen_r;
  assign rsp_header           = rsp_header_r;
  assign rsp_payload          = rsp_payload_r;
  assign err_bad_req          = err_bad_req_r;
  assign err_timeout          = err_timeout_r;

endmodule
